// File: rtl/rgb_pwm_gen.sv
// Three-channel RGB PWM generator; duties are double-buffered and take effect at period boundaries.
// Optional macro RGB_PWM_FADE_EN: shadows step one count per period toward the duty (soft start from 0).
module rgb_pwm_gen #(
  parameter int PRESCALE_W = 8,
  parameter int PERIOD_MAX = 254
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [7:0]            duty_red,
  input  logic [7:0]            duty_green,
  input  logic [7:0]            duty_blue,
  output logic                  pwm_red,
  output logic                  pwm_green,
  output logic                  pwm_blue,
  output logic                  period_end,
  output logic                  busy
);
  localparam logic [7:0] CNT_MAX = 8'(PERIOD_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic [PRESCALE_W-1:0] pcnt_reg, pcnt_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic                  active, tick, wrap, start, stop;
  logic                  period_end_reg, busy_reg;
  logic [2:0][7:0]       duty_vec;
  logic [2:0]            pwm_vec;

  assign duty_vec = {duty_blue, duty_green, duty_red};

  always_comb begin
    active = (state_reg != IDLE);
    // >= rather than == so a lowered prescale ticks immediately instead of wrapping around
    tick   = active && (pcnt_reg >= prescale);
    wrap   = tick && (cnt_reg == CNT_MAX);
    start  = (state_reg == IDLE) && enable;
    stop   = (state_reg == DRAIN) && wrap && !enable;
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN:   if (wrap) state_next = enable ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pcnt_next = '0;
    cnt_next  = 8'd0;
    if (active) begin
      pcnt_next = tick ? '0 : pcnt_reg + PRESCALE_W'(1);
      if (!wrap) cnt_next = tick ? cnt_reg + 8'd1 : cnt_reg;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [7:0] shadow_reg, shadow_next;
    logic       pwm_reg;

    always_comb begin
      shadow_next = shadow_reg;
`ifdef RGB_PWM_FADE_EN
      if (start) shadow_next = 8'd0;
      else if (wrap && (shadow_reg < duty_vec[gi])) shadow_next = shadow_reg + 8'd1;
      else if (wrap && (shadow_reg > duty_vec[gi])) shadow_next = shadow_reg - 8'd1;
`else
      if (start || wrap) shadow_next = duty_vec[gi];
`endif
    end

    // The final drain edge clears the pin together with the period_end pulse
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_reg <= 8'd0;
        pwm_reg    <= 1'b0;
      end else begin
        shadow_reg <= shadow_next;
        pwm_reg    <= active && !stop && (cnt_reg < shadow_reg);
      end
    end

    assign pwm_vec[gi] = pwm_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pcnt_reg       <= '0;
      cnt_reg        <= 8'd0;
      period_end_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pcnt_reg       <= pcnt_next;
      cnt_reg        <= cnt_next;
      period_end_reg <= wrap;
      busy_reg       <= (state_next != IDLE);
    end
  end

  assign pwm_red    = pwm_vec[0];
  assign pwm_green  = pwm_vec[1];
  assign pwm_blue   = pwm_vec[2];
  assign period_end = period_end_reg;
  assign busy       = busy_reg;
endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Self-checking bench for rgb_pwm_gen: per-period high-time/length measurement against a
// period-level model of latched shadows (handles RGB_PWM_FADE_EN when defined).
module tb_rgb_pwm_gen;
  logic       clk = 1'b0;
  logic       rst, enable;
  logic [7:0] prescale, duty_red, duty_green, duty_blue;
  logic       pwm_red, pwm_green, pwm_blue, period_end, busy;

  int checks   = 0;
  int failures = 0;
  int exp_sh [3];

  always #5 clk = ~clk;

  rgb_pwm_gen #(.PRESCALE_W(8), .PERIOD_MAX(254)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (prescale),
    .duty_red   (duty_red),
    .duty_green (duty_green),
    .duty_blue  (duty_blue),
    .pwm_red    (pwm_red),
    .pwm_green  (pwm_green),
    .pwm_blue   (pwm_blue),
    .period_end (period_end),
    .busy       (busy)
  );

  // Shadow value for the next period given the current one and the duty seen at the boundary
  function automatic int adv(int sh, int d);
`ifdef RGB_PWM_FADE_EN
    if (sh < d) return sh + 1;
    if (sh > d) return sh - 1;
    return sh;
`else
    return d;
`endif
  endfunction

  function automatic int start_sh(int d);
`ifdef RGB_PWM_FADE_EN
    return 0;
`else
    return d;
`endif
  endfunction

  // mode 0: plain period; 1: period that drains into IDLE; 2: prescale 200 dropped to 5 at pcnt=150
  function automatic int exp_hi(int sh, int p, int mode);
    if (mode == 2) return (sh == 0) ? 0 : 151 + 6 * (sh - 1);
    if (mode == 1) return sh * (p + 1) - ((sh == 255) ? 1 : 0);
    return sh * (p + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_duty(input int r, input int g, input int b);
    duty_red   = 8'(r);
    duty_green = 8'(g);
    duty_blue  = 8'(b);
  endtask

  task automatic latch_sh();
    exp_sh[0] = adv(exp_sh[0], int'(duty_red));
    exp_sh[1] = adv(exp_sh[1], int'(duty_green));
    exp_sh[2] = adv(exp_sh[2], int'(duty_blue));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".pins"}, 32'({pwm_red, pwm_green, pwm_blue}), 32'd0);
    chk({tag, ".period_end"}, 32'(period_end), 32'd0);
  endtask

  task automatic begin_run(input string tag);
    enable = 1'b1;
    @(negedge clk);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".pins"}, 32'({pwm_red, pwm_green, pwm_blue}), 32'd0);
    exp_sh[0] = start_sh(int'(duty_red));
    exp_sh[1] = start_sh(int'(duty_green));
    exp_sh[2] = start_sh(int'(duty_blue));
  endtask

  // Measure one period window (through the period_end sample), applying optional mid-window changes
  task automatic run_win(input string tag, input int p, input int mode,
                         input int chg_at, input int nr, input int ng, input int nb,
                         input int ps_at, input int np, input int en_at, input logic en_v);
    int n, hr, hg, hb, bl, e_len, er, eg, eb;
    bit done;
    n = 0; hr = 0; hg = 0; hb = 0; bl = 0; done = 1'b0;
    e_len = (mode == 2) ? 1675 : 255 * (p + 1);
    er = exp_hi(exp_sh[0], p, mode);
    eg = exp_hi(exp_sh[1], p, mode);
    eb = exp_hi(exp_sh[2], p, mode);
    while (!done && n < 2 * e_len + 16) begin
      @(negedge clk);
      n++;
      hr += int'(pwm_red);
      hg += int'(pwm_green);
      hb += int'(pwm_blue);
      if (busy !== 1'b1) bl++;
      if (period_end === 1'b1) done = 1'b1;
      else begin
        if (n == chg_at) set_duty(nr, ng, nb);
        if (n == ps_at) prescale = 8'(np);
        if (n == en_at) enable = en_v;
      end
    end
    $display("window %s: len=%0d high r/g/b=%0d/%0d/%0d busy_low=%0d", tag, n, hr, hg, hb, bl);
    chk({tag, ".len"}, n, e_len);
    chk({tag, ".red"}, hr, er);
    chk({tag, ".green"}, hg, eg);
    chk({tag, ".blue"}, hb, eb);
    chk({tag, ".busy_low"}, bl, (mode == 1) ? 1 : 0);
    latch_sh();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; prescale = 8'd0;
    set_duty(0, 0, 0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    set_duty(64, 128, 255);
    @(negedge clk);
    check_idle("idle");

    begin_run("start");
    run_win("basic",     0, 0, -1,    0,   0,   0, -1, 0, -1, 1'b1);
    run_win("shadow",    0, 0, 100, 200, 128, 255, -1, 0, -1, 1'b1);
    run_win("shadow_nx", 0, 0, 100,   0, 254, 255, -1, 0, -1, 1'b1);
    run_win("bounds",    0, 0, 100,  10, 100, 255, -1, 0, -1, 1'b1);
    prescale = 8'd3;
    run_win("ps3",       3, 0, -1,    0,   0,   0, -1, 0, -1, 1'b1);
    prescale = 8'd200;
    run_win("ps_drop", 200, 2, -1,    0,   0,   0, 150, 5, -1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int p;
      p = int'($urandom_range(0, 2));
      prescale = 8'(p);
      run_win($sformatf("rand%0d", k), p, 0, int'($urandom_range(1, 200)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), -1, 0, -1, 1'b1);
    end

    // enable falls on the wrap cycle: a full period is drained with fresh shadows
    prescale = 8'd0;
    set_duty(30, 0, 255);
    run_win("fall",       0, 0, -1, 0, 0, 0, -1, 0, 254, 1'b0);
    run_win("drain_full", 0, 1, -1, 0, 0, 0, -1, 0, -1, 1'b0);
    @(negedge clk);
    check_idle("after_drain");

    set_duty(64, 128, 255);
    begin_run("restart");
    run_win("drain50", 0, 1, -1, 0, 0, 0, -1, 0, 50, 1'b0);
    @(negedge clk);
    check_idle("after_drain50");

    begin_run("restart2");
    run_win("run", 0, 0, -1, 0, 0, 0, -1, 0, -1, 1'b1);
    enable = 1'b0;
    run_win("redrain", 0, 0, -1, 0, 0, 0, -1, 0, 100, 1'b1);
    run_win("cont",    0, 0, -1, 0, 0, 0, -1, 0, -1, 1'b1);

    repeat (120) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_gen.md
Name: rgb_pwm_gen

Overview:
Three-channel PWM generator driving the red/green/blue LED pins. It consumes the pwm_duty_red/green/blue and enable_stuf fields of the sys_cfg register-bank wire struct. Duty values are double-buffered: register writes land in shadow registers only at a PWM period boundary, so outputs never glitch mid-period. Sits directly downstream of the register bank, between it and the pad ring.

Parameters:
PRESCALE_W, 8, width of the prescale input and the internal prescale counter
PERIOD_MAX, 254, terminal value of the 8-bit PWM counter; period = PERIOD_MAX+1 ticks

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  run request (from enable_stuf)
prescale  input  PRESCALE_W  tick divider; one PWM tick every prescale+1 clk cycles
duty_red  input  8  red duty, on-ticks per period
duty_green  input  8  green duty
duty_blue  input  8  blue duty
pwm_red  output  1  red PWM out, registered
pwm_green  output  1  green PWM out, registered
pwm_blue  output  1  blue PWM out, registered
period_end  output  1  one-clk pulse on the last tick of every period while active
busy  output  1  high in RUN or DRAIN

Behaviour:
- Clock/reset: single clock clk; rst is synchronous and active-high. Reset forces state IDLE; prescale counter, PWM counter and all shadows to 0; all outputs to 0.
- Prescaler: pcnt counts 0..prescale; tick=1 when pcnt>=prescale, pcnt then returns to 0. The >= compare means lowering prescale below the current pcnt yields a tick on the next cycle, never a 2^PRESCALE_W wrap. prescale=0 gives a tick every cycle. pcnt is held at 0 in IDLE.
- PWM counter cnt (8 bit): advances on tick, 0..PERIOD_MAX, then wraps to 0. Wrap condition is wrap = tick && cnt==PERIOD_MAX.
- Compare: pwm_x registered as (cnt < shadow_x), giving 1 clk latency from cnt to pin. duty 0 is constant low; duty>=255 is constant high (255 > PERIOD_MAX).
- Shadow load: shadow_x <= duty_x on wrap, and on the IDLE->RUN transition. Input changes at any other time have no effect until the next wrap.
- period_end = wrap, registered to align with the pin outputs. It pulses only in RUN or DRAIN.
- FSM:
  - IDLE: outputs 0, counters held at 0. Goes to RUN when enable=1. On entry, shadows are loaded, cnt=0, pcnt=0; first pin update one clk later.
  - RUN: normal operation. Goes to DRAIN when enable=0.
  - DRAIN: completes the current period with the current shadows. On wrap: go to RUN if enable=1 (with shadow load), else go to IDLE with all pwm outputs cleared on the same edge as period_end. enable toggling within DRAIN has no effect before the wrap.
- busy = (state != IDLE), registered.
- Simultaneous events: a wrap and an enable fall in the same cycle in RUN gives RUN->DRAIN, and a full new period is drained with the freshly loaded shadows. rst dominates all other events.
- Reset mid-period: outputs go low on the next edge; no drain.

Optional Feature:
RGB_PWM_FADE_EN. When defined, on each wrap every shadow_x steps by 1 toward duty_x (+1 if lower, -1 if higher, hold if equal) instead of loading directly. The IDLE->RUN load also starts from shadow 0, so LEDs soft-start. A full 0->255 fade takes 255 periods. When undefined, shadows load duty_x directly as described above; no extra logic is present.

Test Plan:
- Basic duty: rst, prescale=0, duty r/g/b=64/128/255, enable=1 -> pwm_red high 64 of every 255 clks, green 128, blue constant 1; period_end every 255 clks.
- Boundary duties: duty=0 -> pin never high; duty=254 -> low exactly 1 clk per period; duty=255 -> never low while RUN.
- Shadowing: mid-period (cnt=100) change duty_red 64->200 -> current period still 64 high; next period 200 high; change visible only after period_end.
- Prescale: prescale=3, duty=10 -> high 40 clks, period 1020 clks. Drop prescale from 200 to 5 while pcnt=150 -> tick next cycle, no long gap.
- Drain: deassert enable at cnt=50 -> pins keep toggling to period end; IDLE with pins=0 and busy=0 on the period_end edge. Re-assert enable at cnt=100 of the drain -> seamless continuation, busy stays 1.
- Reset/fade: assert rst at cnt=120 -> all outputs 0 next clk. With RGB_PWM_FADE_EN, duty_red 0->5 -> high-times 1,2,3,4,5,5 over successive periods.
